// File: rtl/sha256_mem_host.sv
// Host-side wrapper for a memory-mapped SHA-256 core: packs a byte stream into word memory,
// kicks the core, serves its memory port, then streams the 8-word digest back out.
module sha256_mem_host #(
   parameter int unsigned DEPTH    = 1024,
   parameter logic [15:0] MSG_BASE = 16'h0000,
   parameter logic [15:0] OUT_BASE = 16'h0200
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   input  logic        in_last,
   output logic        in_ready,
   output logic        start,
   output logic [31:0] message_addr,
   output logic [31:0] output_addr,
   output logic [31:0] size,
   input  logic        done,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [31:0] mem_write_data,
   output logic [31:0] mem_read_data,
   output logic        dig_valid,
   output logic [31:0] dig_data,
   output logic        dig_last,
   input  logic        dig_ready,
   output logic        busy,
   output logic        err
);

   localparam int unsigned AW  = $clog2(DEPTH);
   // Message bytes that fit below the digest area.
   localparam logic [31:0] CAP = {14'd0, OUT_BASE - MSG_BASE, 2'b00};

   typedef enum logic [2:0] {StLoad, StFlush, StStart, StRun, StReadout} state_e;

   state_e      state_q, state_d;
   logic [31:0] mem [DEPTH];
   logic [31:0] cnt_q, size_q, word_q, wbuf_q, rd_q;
   logic [15:0] waddr_q, host_addr, host_wa, rd_addr;
   logic [31:0] host_wd;
   logic [1:0]  lane_q;
   logic [2:0]  idx_q;
   logic        wpend_q, done_q, err_q, dv_q;
   logic        acc, counted, rise, hs, last_hs, host_we, core_we;
   logic        unused_bits;

   assign acc       = in_valid && in_ready;
   assign counted   = acc && (cnt_q < CAP);
   assign rise      = done && !done_q;
   assign hs        = dv_q && dig_ready;
   assign last_hs   = hs && (idx_q == 3'd7);
   assign host_addr = MSG_BASE + cnt_q[17:2];
   assign host_we   = wpend_q || (state_q == StFlush && lane_q != 2'd0);
   assign host_wa   = wpend_q ? waddr_q : host_addr;
   assign host_wd   = wpend_q ? wbuf_q : word_q;
   assign core_we   = (state_q == StRun) && mem_we;
   assign rd_addr   = (state_q == StReadout) ? OUT_BASE + {13'd0, idx_q} : mem_addr;

   assign message_addr  = {16'd0, MSG_BASE};
   assign output_addr   = {16'd0, OUT_BASE};
   assign size          = size_q;
   assign err           = err_q;
   assign mem_read_data = rd_q;
   assign dig_data      = rd_q;
   assign dig_valid     = dv_q;
   assign dig_last      = dv_q && (idx_q == 3'd7);
   assign unused_bits   = ^{mem_addr, rd_addr, host_wa, cnt_q};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StLoad;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StLoad:    if (acc && in_last) state_d = StFlush;
         StFlush:   state_d = StStart;
         StStart:   state_d = StRun;
         StRun:     if (rise) state_d = StReadout;
         StReadout: if (last_hs) state_d = StLoad;
         default:   state_d = StLoad;
      endcase
   end

   always_comb begin
      in_ready = 1'b0;
      start    = 1'b0;
      busy     = 1'b1;
      unique case (state_q)
         StLoad:  begin in_ready = 1'b1; busy = 1'b0; end
         StStart: start = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q   <= '0;
         size_q  <= '0;
         word_q  <= '0;
         wbuf_q  <= '0;
         waddr_q <= '0;
         lane_q  <= '0;
         idx_q   <= '0;
         wpend_q <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         dv_q    <= 1'b0;
      end else begin
         done_q  <= done;
         wpend_q <= 1'b0;
         if (counted) begin
            case (lane_q)
               2'd0: word_q[31:24] <= in_data;
               2'd1: word_q[23:16] <= in_data;
               2'd2: word_q[15:8]  <= in_data;
               default: begin
                  // Full word goes out next cycle from a side buffer so packing never stalls.
                  wbuf_q  <= {word_q[31:8], in_data};
                  waddr_q <= host_addr;
                  wpend_q <= 1'b1;
                  word_q  <= '0;
               end
            endcase
            lane_q <= lane_q + 2'd1;
            cnt_q  <= cnt_q + 32'd1;
            size_q <= cnt_q + 32'd1;
         end
         if (acc && !counted) err_q <= 1'b1;
         if (state_q == StReadout) begin
            if (hs) begin
               dv_q  <= 1'b0;
               idx_q <= idx_q + 3'd1;
            end else begin
               dv_q <= 1'b1;
            end
            if (last_hs) begin
               cnt_q  <= '0;
               lane_q <= '0;
               word_q <= '0;
            end
         end else begin
            dv_q  <= 1'b0;
            idx_q <= '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (core_we)      mem[mem_addr[AW-1:0]] <= mem_write_data;
      else if (host_we) mem[host_wa[AW-1:0]]  <= host_wd;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) rd_q <= '0;
      else          rd_q <= mem[rd_addr[AW-1:0]];
   end

endmodule

// File: tb/tb_sha256_mem_host.sv
// Directed bench for sha256_mem_host: byte packing, core memory port, digest readout,
// overflow and mid-readout reset, with a queue scoreboard for digest words.
module tb_sha256_mem_host;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid, in_last, in_ready, start, done, mem_we;
   logic [7:0]  in_data;
   logic [31:0] message_addr, output_addr, size, mem_write_data, mem_read_data, dig_data;
   logic [15:0] mem_addr;
   logic        dig_valid, dig_last, dig_ready, busy, err;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] exp_q[$];

   localparam logic [15:0] OB = 16'h0200;

   always #5 clk = ~clk;

   sha256_mem_host dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
      .in_ready(in_ready), .start(start), .message_addr(message_addr),
      .output_addr(output_addr), .size(size), .done(done), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_write_data(mem_write_data), .mem_read_data(mem_read_data),
      .dig_valid(dig_valid), .dig_data(dig_data), .dig_last(dig_last), .dig_ready(dig_ready),
      .busy(busy), .err(err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   // Called in the FLUSH cycle; ends two cycles into RUN.
   task automatic to_run(input string tag);
      int ns = 0;
      for (int k = 0; k < 4; k++) begin
         if (start === 1'b1) ns++;
         if (k < 3) tick();
      end
      chk({tag, "_start_pulses"}, ns, 1);
      chk({tag, "_busy_run"}, {31'd0, busy}, 1);
   endtask

   task automatic core_write(input logic [15:0] a, input logic [31:0] d);
      mem_we         = 1'b1;
      mem_addr       = a;
      mem_write_data = d;
      tick();
      mem_we = 1'b0;
   endtask

   task automatic core_read(input string tag, input logic [15:0] a, input logic [31:0] expv);
      mem_addr = a;
      tick();
      chk(tag, mem_read_data, expv);
   endtask

   task automatic raise_done(input string tag);
      dig_ready = 1'b0;
      done = 1'b0;
      tick();
      done = 1'b1;
      tick();
      chk({tag, "_valid_early"}, {31'd0, dig_valid}, 0);
      tick();
      chk({tag, "_valid_w0"}, {31'd0, dig_valid}, 1);
      chk({tag, "_data_w0"}, dig_data, exp_q[0]);
   endtask

   task automatic drain(input string tag, input bit toggle);
      int got = 0;
      logic v, r, l;
      logic [31:0] d, e;
      for (int c = 0; c < 100 && got < 8; c++) begin
         dig_ready = toggle ? ~dig_ready : 1'b1;
         v = dig_valid; r = dig_ready; d = dig_data; l = dig_last;
         tick();
         if (v && r) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
            chk({tag, "_word"}, d, e);
            chk({tag, "_last"}, {31'd0, l}, {31'd0, exp_q.size() == 0});
            got++;
         end else if (v) begin
            chk({tag, "_hold_valid"}, {31'd0, dig_valid}, 1);
            chk({tag, "_hold_data"}, dig_data, d);
         end
      end
      chk({tag, "_count"}, got, 8);
      chk({tag, "_valid_after"}, {31'd0, dig_valid}, 0);
      chk({tag, "_back_to_load"}, {31'd0, in_ready}, 1);
      dig_ready = 1'b0;
   endtask

   task automatic push_digest();
      for (int i = 0; i < 8; i++) exp_q.push_back(32'hA0 + i);
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; done = 1'b0;
      mem_we = 1'b0; mem_addr = '0; mem_write_data = '0; dig_ready = 1'b0;
      tick(); tick();
      chk("rst_rdata", mem_read_data, 0);
      chk("rst_size", size, 0);
      chk("rst_start", {31'd0, start}, 0);
      chk("rst_dig_valid", {31'd0, dig_valid}, 0);
      chk("rst_dig_last", {31'd0, dig_last}, 0);
      chk("rst_err", {31'd0, err}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 1);
      chk("message_addr", message_addr, 32'h0);
      chk("output_addr", output_addr, 32'h200);
      reset_n = 1'b1;
      tick();

      // Message "abc"
      send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
      chk("abc_in_ready_flush", {31'd0, in_ready}, 0);
      chk("abc_size", size, 3);
      to_run("abc");
      core_read("abc_word0", 16'h0000, 32'h61626300);
      mem_we = 1'b1; mem_addr = 16'h0000; mem_write_data = 32'h1111_1111;
      tick();
      mem_we = 1'b0;
      chk("rdw_old", mem_read_data, 32'h61626300);
      tick();
      chk("rdw_new", mem_read_data, 32'h1111_1111);
      core_write(16'h0002, 32'hDEAD_BEEF);
      for (int i = 0; i < 8; i++) core_write(OB + 16'(i), 32'hA0 + i);
      push_digest();
      raise_done("rd1");
      drain("rd1", 1'b1);
      chk("size_hold", size, 3);

      // 8-byte message with done still high; load-phase core writes must be ignored
      mem_we = 1'b1; mem_addr = OB; mem_write_data = 32'h5555_5555;
      for (int i = 0; i < 8; i++) send(8'(i), i == 7);
      mem_we = 1'b0;
      chk("m8_size", size, 8);
      to_run("m8");
      for (int k = 0; k < 4; k++) tick();
      chk("stale_done_valid", {31'd0, dig_valid}, 0);
      chk("stale_done_busy", {31'd0, busy}, 1);
      core_read("m8_word0", 16'h0000, 32'h00010203);
      core_read("m8_word1", 16'h0001, 32'h04050607);
      core_read("m8_no_extra", 16'h0002, 32'hDEAD_BEEF);
      core_read("m8_out_kept", OB, 32'hA0);
      push_digest();
      raise_done("rd2");
      drain("rd2", 1'b0);

      // Reset in the middle of READOUT
      send(8'hAA, 1'b1);
      to_run("m1");
      push_digest();
      raise_done("rd3");
      #2 reset_n = 1'b0;
      #1;
      chk("mid_rst_dig_valid", {31'd0, dig_valid}, 0);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
      chk("mid_rst_busy", {31'd0, busy}, 0);
      chk("mid_rst_size", size, 0);
      chk("mid_rst_rdata", mem_read_data, 0);
      exp_q.delete();
      done = 1'b0;
      tick();
      reset_n = 1'b1;
      tick();
      send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b1);
      chk("post_rst_size", size, 3);
      to_run("post_rst");
      core_read("post_rst_word0", 16'h0000, 32'h61626300);
      push_digest();
      raise_done("rd4");
      drain("rd4", 1'b1);

      // Overflow: one byte more than fits below OUT_BASE
      for (int i = 0; i < 2048; i++) send(8'(i), 1'b0);
      chk("ovf_err_before", {31'd0, err}, 0);
      send(8'h77, 1'b1);
      chk("ovf_err", {31'd0, err}, 1);
      chk("ovf_size", size, 2048);
      to_run("ovf");
      core_read("ovf_last_word", 16'h01FF, 32'hFCFDFEFF);
      core_read("ovf_out_kept", OB, 32'hA0);
      chk("ovf_err_sticky", {31'd0, err}, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
